// File: rtl/fanout_pkg.sv
// -----------------------------------------------------------------------------
// fanout_pkg
// Shared definitions for the fanout eager fork and its helpers.
//   NUM_OUT_DEF   : default number of fanout branches
//   DATA_W_DEF    : default stream word width (MSB is the control/done flag)
//   stream_word_t : one stream word at the default width
//   branch_mask_t : one bit per branch at the default branch count
// -----------------------------------------------------------------------------
package fanout_pkg;

    localparam int NUM_OUT_DEF = 6;
    localparam int DATA_W_DEF  = 17;

    typedef logic [DATA_W_DEF-1:0]  stream_word_t;
    typedef logic [NUM_OUT_DEF-1:0] branch_mask_t;

endpackage

// File: rtl/fanout_stall_counter.sv
// -----------------------------------------------------------------------------
// fanout_stall_counter
// Saturating event counter used to measure upstream stall cycles.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (count -> 0)
//   clk_en : update enable; count holds while low
//   clr    : synchronous clear (qualified by clk_en), wins over inc
//   inc    : add one this cycle unless already at the maximum
//   count  : current count, saturates at 2^W-1
// -----------------------------------------------------------------------------
module fanout_stall_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clk_en) begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fanout_eager_fork.sv
// -----------------------------------------------------------------------------
// fanout_eager_fork
// Eager fork of one upstream stream onto NUM_OUT branches. Each enabled branch
// may accept the current token independently; the upstream sees ready only
// once every enabled branch has taken the token (earlier or this cycle).
// Data and valid are combinational broadcasts: zero-cycle latency.
//
// Optional feature: define FANOUT_FORK_STALL_CNT_EN to build a saturating
// counter of upstream stall cycles (in_valid & ~in_ready). Without it,
// stall_count is tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clk_en      : state update enable (sent mask and stall counter)
//   flush       : synchronous clear of branch tracking and stall count
//   cfg_en      : per-branch enable (quasi-static)
//   in_data/in_valid/in_ready : upstream stream
//   out_data    : branch i on slice [i*DATA_W +: DATA_W]
//   out_valid/out_ready       : per-branch handshake
//   stall_count : saturating upstream stall count
// -----------------------------------------------------------------------------
module fanout_eager_fork
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STALL_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      flush,
    input  logic [NUM_OUT-1:0]        cfg_en,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [STALL_W-1:0]        stall_count
);

    // sent_reg[i]: branch i already accepted the current token
    logic [NUM_OUT-1:0] sent_reg;
    logic [NUM_OUT-1:0] sent_next;
    logic [NUM_OUT-1:0] take;
    // clear[i]: branch i does not hold back the upstream this cycle
    logic [NUM_OUT-1:0] clear;
    logic               xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_branch
            assign out_data[gi*DATA_W +: DATA_W] = in_data;
            assign out_valid[gi] = in_valid & cfg_en[gi] & ~sent_reg[gi];
            assign take[gi]      = out_valid[gi] & out_ready[gi];
            assign clear[gi]     = ~cfg_en[gi] | sent_reg[gi] | out_ready[gi];
        end
    endgenerate

    // With every branch disabled, clear is all ones: tokens are dropped.
    assign in_ready = &clear;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        sent_next = sent_reg;
        if (flush || xfer) begin
            sent_next = '0;
        end else begin
            sent_next = sent_reg | take;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_reg <= '0;
        end else if (clk_en) begin
            sent_reg <= sent_next;
        end
    end

`ifdef FANOUT_FORK_STALL_CNT_EN
    fanout_stall_counter #(
        .W (STALL_W)
    ) u_stall_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .clr    (flush),
        .inc    (in_valid & ~in_ready),
        .count  (stall_count)
    );
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fanout_eager_fork.sv
// -----------------------------------------------------------------------------
// tb_fanout_eager_fork
// Directed scenarios followed by a randomized phase, every cycle compared
// against a token-level reference model (which branches already hold the
// current token, how many stall cycles have been seen).
// -----------------------------------------------------------------------------
module tb_fanout_eager_fork;
    import fanout_pkg::*;

    localparam int N    = NUM_OUT_DEF;
    localparam int DW   = DATA_W_DEF;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clk_en = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    cfg_en = '0;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready = '0;
    logic [SW-1:0]   stall_count;

    always #5 clk = ~clk;

    fanout_eager_fork #(
        .NUM_OUT (N),
        .DATA_W  (DW),
        .STALL_W (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .flush       (flush),
        .cfg_en      (cfg_en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stall_count (stall_count)
    );

    int total = 0;
    int passed = 0;

    // Reference model: which branches already own the current token.
    bit accepted [N];
    int stalls = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m_ready();
        int blockers = 0;
        for (int i = 0; i < N; i++)
            if (cfg_en[i] && !accepted[i] && !out_ready[i]) blockers++;
        return blockers == 0;
    endfunction

    function automatic logic [N-1:0] m_valid();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++)
            v[i] = in_valid && cfg_en[i] && !accepted[i];
        return v;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < N; i++) accepted[i] = 1'b0;
    endfunction

    // Called ~1 time unit after a rising edge with inputs already driven:
    // compare outputs, advance the model, then move to just past next edge.
    task automatic step(input string tag);
        logic [N-1:0] v;
        bit r;
        #1;
        v = m_valid();
        r = m_ready();
        chk({tag, ".in_ready"},    128'(in_ready),    128'(r));
        chk({tag, ".out_valid"},   128'(out_valid),   128'(v));
        chk({tag, ".out_data"},    128'(out_data),    128'({N{in_data}}));
        chk({tag, ".stall_count"}, 128'(stall_count), 128'(stalls));
        $display("%s: in_valid=%0b cfg_en=%b out_ready=%b in_ready=%0b out_valid=%b stall=%0d",
                 tag, in_valid, cfg_en, out_ready, in_ready, out_valid, stall_count);
        if (clk_en) begin
            if (flush) begin
                m_clear();
                stalls = 0;
            end else begin
`ifdef FANOUT_FORK_STALL_CNT_EN
                if (in_valid && !r && stalls < SMAX) stalls++;
`endif
                if (in_valid && r) m_clear();
                else for (int i = 0; i < N; i++) if (v[i] && out_ready[i]) accepted[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        cfg_en   = '1;
        in_valid = 1'b1;
        in_data  = 17'h1_0003;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 128'(out_valid), 128'({N{1'b1}}));
        chk("reset.stall_count", 128'(stall_count), 128'(0));
        rst_n = 1'b1;
        m_clear();

        // Full fanout in one cycle
        in_data = 17'h00A5; out_ready = '1;
        step("full0");
        step("full1");

        // Partial acceptance on branches 0..2
        cfg_en = 6'b000111; in_data = 17'h1_2345;
        out_ready = 6'b000001; step("part_c0");
        out_ready = 6'b000010; step("part_c1");
        out_ready = 6'b000000; step("part_c2");
        out_ready = 6'b000100; step("part_c3");
        out_ready = 6'b000000; step("part_c4");

        // All branches disabled: tokens dropped
        cfg_en = '0;
        for (int k = 0; k < 4; k++) begin
            in_data = DW'(k * 7 + 1);
            step("drop");
        end

        // Flush after a partial acceptance
        cfg_en = 6'b000011; in_data = 17'h0_0F0F;
        out_ready = 6'b000001; step("flush_take");
        out_ready = 6'b000000; flush = 1'b1; step("flush_on");
        flush = 1'b0; step("flush_after");

        // clk_en low freezes tracking
        out_ready = 6'b000010; clk_en = 1'b0; step("hold");
        out_ready = 6'b000000; clk_en = 1'b1; step("hold_after");
        flush = 1'b1; step("hold_flush"); flush = 1'b0;

        // Asynchronous reset mid-token on branch 3
        cfg_en = '1; out_ready = 6'b001000; step("rst_take");
        out_ready = '0;
        #1;
        chk("rst_pre.out_valid3", 128'(out_valid[3]), 128'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async.out_valid", 128'(out_valid), 128'({N{1'b1}}));
        m_clear();
        stalls = 0;
        rst_n = 1'b1;
        step("rst_after");
        flush = 1'b1; step("rst_flush"); flush = 1'b0;

        // Stall counting: 10 cycles, then saturation over 20
        cfg_en = 6'b000001; out_ready = '0;
        for (int k = 0; k < 10; k++) step("stall10");
        chk("stall10.count", 128'(stall_count), 128'(stalls));
        flush = 1'b1; step("stall_flush"); flush = 1'b0;
        for (int k = 0; k < 20; k++) step("stall20");
        chk("stall20.count", 128'(stall_count), 128'(stalls));

        // Randomized phase; cfg_en only changes between tokens
        for (int k = 0; k < 300; k++) begin
            bit idle = 1'b1;
            for (int i = 0; i < N; i++) if (accepted[i]) idle = 1'b0;
            if (idle && $urandom_range(0, 7) == 0) cfg_en = N'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = N'($urandom);
            clk_en    = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fanout_eager_fork.md
# fanout_eager_fork

Producer-side eager fork for one stream feeding up to NUM_OUT consumers in the sparse-stream fabric. It is the sending end of the fanout ready-combine path: it drives per-branch valid/data and tracks which enabled branches have already accepted the current token. It returns ready to the upstream producer only once every enabled branch has taken the token, either earlier or in the current cycle. It sits between a stream source (primitive or memory tile output) and the routed fanout branches.

## Interface
Parameters:
- NUM_OUT, 6, number of fanout branches (1..16)
- DATA_W, 17, stream word width (bit DATA_W-1 is the control/done flag, passed through untouched)
- STALL_W, 16, width of the stall counter (used only when FANOUT_FORK_STALL_CNT_EN is defined)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  state update enable; when low, all registers hold
- flush  in  1  synchronous clear of branch-tracking state (qualified by clk_en)
- cfg_en  in  NUM_OUT  per-branch enable, quasi-static configuration
- in_data  in  DATA_W  upstream word
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- out_data  out  NUM_OUT*DATA_W  per-branch word; branch i occupies slice [i*DATA_W +: DATA_W]
- out_valid  out  NUM_OUT  per-branch valid
- out_ready  in  NUM_OUT  per-branch ready
- stall_count  out  STALL_W  saturating count of upstream stall cycles

## Operation
- State: sent[NUM_OUT]. Bit i is set when branch i has accepted the current token.
- out_data[i] = in_data for every i (combinational broadcast).
- out_valid[i] = in_valid & cfg_en[i] & ~sent[i].
- take[i] = out_valid[i] & out_ready[i].
- in_ready = AND over i of (~cfg_en[i] | sent[i] | out_ready[i]).
- Upstream handshake: xfer = in_valid & in_ready.
- sent update on clk rising edge while clk_en=1, in priority order:
  - flush=1: sent <= 0.
  - xfer=1: sent <= 0, ready for the next token.
  - Otherwise: sent <= sent | take.
- Per-token state machine per branch: PENDING (sent=0) -> DONE (sent=1) on take without xfer. DONE -> PENDING on xfer or flush.
- A branch accepts each token exactly once. A branch in DONE never sees valid again until xfer.
- All branches disabled (cfg_en=0): in_ready=1 and out_valid=0; tokens are consumed and dropped.
- cfg_en changing mid-token is not supported. The result is defined only in that a newly disabled branch no longer blocks in_ready.
- in_valid dropping before xfer: sent holds; this is a protocol violation upstream, and no recovery is attempted beyond flush.

## Timing
- Valid/data and in_ready are combinational from their inputs. There is no register in the data path, so latency is 0 cycles.
- Single-cycle full fanout: if all enabled branches are ready in the same cycle, xfer occurs that cycle.
- Partial acceptance: a token completes in the cycle the last pending branch asserts ready. Earlier-accepting branches are not stalled in the meantime.
- Reset values: sent=0 and stall_count=0. Outputs follow from these: out_valid=in_valid&cfg_en, and in_ready equals the combinational expression.
- Reset mid-token: all branches return to PENDING, so previously accepted branches receive the token again. This is acceptable because reset flushes the fabric.
- clk_en=0: sent and stall_count hold; combinational outputs still track their inputs.

## Configuration
- FANOUT_FORK_STALL_CNT_EN defined:
  - stall_count increments by 1 each clk_en cycle with in_valid & ~in_ready.
  - It saturates at 2^STALL_W-1.
  - flush clears it.
- Not defined: stall_count is tied to 0 and no counter flops exist.

## Structure
- Shared package fanout_pkg holds:
  - the default NUM_OUT and DATA_W constants;
  - typedef stream_word_t (logic [DATA_W-1:0]);
  - typedef branch_mask_t (logic [NUM_OUT-1:0]).
- Sub-module fanout_stall_counter: saturating counter with inc, clr, clk_en and count. It is instantiated only under the macro.

## Test plan
- All 6 enabled, all out_ready=1, in_valid=1 with data 0x00A5 -> xfer same cycle; every out_valid=1; out_data=0x00A5 on all slices; sent stays 0.
- cfg_en=6'b000111, branch 0 ready in cycle 0, branch 1 in cycle 1, branch 2 in cycle 3 -> each branch's out_valid falls the cycle after its take. in_ready=1 only in cycle 3; that is the only xfer.
- cfg_en=0, in_valid=1 for 4 cycles -> in_ready=1 every cycle; out_valid=0; 4 tokens dropped.
- Branch 0 taken, then flush=1 before branch 1 ready -> sent cleared; branch 0 out_valid reasserts next cycle.
- Branch 3 sent=1, rst_n low asynchronously mid-cycle -> sent=0 immediately; after release, branch 3 out_valid=1.
- Macro on, cfg_en=1, out_ready[0]=0, in_valid=1 for 10 cycles -> stall_count=10. With STALL_W=4 and 20 stall cycles -> stall_count=15.
